// File: rtl/weight_seq_pkg.sv
// rtl/weight_seq_pkg.sv - shared types, defaults and helpers for the weight sequencer
// Contents: FSM state encoding, default kernel geometry, 9-bit popcount.
package weight_seq_pkg;

    localparam int DEF_KERNEL_SIZE  = 9;
    localparam int DEF_KERNEL_WIDTH = 3;
    localparam int DEF_DATA_WIDTH   = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LD_WEI  = 3'd1,
        ST_KICK    = 3'd2,
        ST_WAIT_EN = 3'd3,
        ST_ROW     = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 9; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - clearable cycle counter with max-compare expiry
// Ports: clk, reset (async high), clear, enable, expired (combinational).
module wait_timer #(
    parameter int MAX_COUNT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(MAX_COUNT + 1);

    logic [CW-1:0] count;

    // expired flags the enabled cycle on which the count reaches MAX_COUNT,
    // so the owner can act on that same edge.
    assign expired = enable && (count == CW'(MAX_COUNT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/weight_seq_ctrl.sv
// rtl/weight_seq_ctrl.sv - sequences one 3x3 weight kernel into the weight buffer
// Ports: upstream flag/weight valid-ready inputs; flag/weight write strobes and
// data, mode, start, row_cal_done to the buffer; wei_en/row_done from buffer/PE;
// busy, kernel_done, err_timeout status. All outputs are registered.
module weight_seq_ctrl
    import weight_seq_pkg::*;
#(
    parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
    parameter int KERNEL_WIDTH = DEF_KERNEL_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int EN_TIMEOUT   = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_mode,
    input  logic                   in_flag_valid,
    input  logic [KERNEL_SIZE-1:0] in_flag,
    output logic                   in_flag_ready,
    input  logic                   in_wei_valid,
    input  logic [DATA_WIDTH-1:0]  in_wei,
    output logic                   in_wei_ready,
    output logic                   wr_req_wei_flag,
    output logic [KERNEL_SIZE-1:0] wr_data_wei_flag,
    output logic                   wr_req_wei,
    output logic [DATA_WIDTH-1:0]  wr_data_wei,
    output logic                   mode,
    output logic                   start,
    input  logic                   wei_en,
    input  logic                   row_done,
    output logic                   row_cal_done,
    output logic                   busy,
    output logic                   kernel_done,
    output logic                   err_timeout
);

    state_t state, state_nxt;

    logic [3:0] wei_left, wei_left_nxt;
    logic [1:0] row_idx, row_idx_nxt;

    logic                   flag_req_nxt, wei_req_nxt;
    logic [KERNEL_SIZE-1:0] flag_data_nxt;
    logic [DATA_WIDTH-1:0]  wei_data_nxt;
    logic                   mode_nxt, start_nxt, row_cal_nxt, err_nxt;
    logic [3:0]             flag_pop;

    logic timer_clear, timer_en, timer_expired;

    // Ready registers mirror the current state, so these are true handshakes.
    logic flag_hs, wei_hs;
    assign flag_hs  = (state == ST_IDLE)   && in_flag_ready && in_flag_valid;
    assign wei_hs   = (state == ST_LD_WEI) && in_wei_ready  && in_wei_valid;
    assign flag_pop = popcount9(in_flag);

    wait_timer #(
        .MAX_COUNT (EN_TIMEOUT)
    ) u_en_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_nxt     = state;
        wei_left_nxt  = wei_left;
        row_idx_nxt   = row_idx;
        flag_req_nxt  = 1'b0;
        wei_req_nxt   = 1'b0;
        flag_data_nxt = wr_data_wei_flag;
        wei_data_nxt  = wr_data_wei;
        mode_nxt      = mode;
        start_nxt     = 1'b0;
        row_cal_nxt   = 1'b0;
        err_nxt       = err_timeout;
        timer_clear   = 1'b0;
        timer_en      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (flag_hs) begin
                    flag_req_nxt  = 1'b1;
                    flag_data_nxt = in_flag;
                    mode_nxt      = cfg_mode;
                    err_nxt       = 1'b0;
                    wei_left_nxt  = flag_pop;
                    state_nxt     = (flag_pop != 4'd0) ? ST_LD_WEI : ST_KICK;
                end
            end
            ST_LD_WEI: begin
                if (wei_hs) begin
                    wei_req_nxt  = 1'b1;
                    wei_data_nxt = in_wei;
                    wei_left_nxt = wei_left - 4'd1;
                    if (wei_left == 4'd1) begin
                        state_nxt = ST_KICK;
                    end
                end
            end
            ST_KICK: begin
                // start lands one cycle after the last write strobe
                start_nxt   = 1'b1;
                timer_clear = 1'b1;
                state_nxt   = ST_WAIT_EN;
            end
            ST_WAIT_EN: begin
                timer_en = 1'b1;
                // wei_en beats an expiry on the same cycle
                if (wei_en) begin
                    if (mode) begin
                        row_idx_nxt = 2'd0;
                        state_nxt   = ST_ROW;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end else if (timer_expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_ROW: begin
                if (row_done) begin
                    row_cal_nxt = 1'b1;
                    row_idx_nxt = row_idx + 2'd1;
                    if (row_idx == 2'(KERNEL_WIDTH - 1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            wei_left         <= '0;
            row_idx          <= '0;
            in_flag_ready    <= 1'b0;
            in_wei_ready     <= 1'b0;
            wr_req_wei_flag  <= 1'b0;
            wr_data_wei_flag <= '0;
            wr_req_wei       <= 1'b0;
            wr_data_wei      <= '0;
            mode             <= 1'b0;
            start            <= 1'b0;
            row_cal_done     <= 1'b0;
            busy             <= 1'b0;
            kernel_done      <= 1'b0;
            err_timeout      <= 1'b0;
        end else begin
            state            <= state_nxt;
            wei_left         <= wei_left_nxt;
            row_idx          <= row_idx_nxt;
            // status outputs describe the state being entered
            in_flag_ready    <= (state_nxt == ST_IDLE);
            in_wei_ready     <= (state_nxt == ST_LD_WEI);
            busy             <= (state_nxt != ST_IDLE);
            kernel_done      <= (state_nxt == ST_DONE);
            wr_req_wei_flag  <= flag_req_nxt;
            wr_data_wei_flag <= flag_data_nxt;
            wr_req_wei       <= wei_req_nxt;
            wr_data_wei      <= wei_data_nxt;
            mode             <= mode_nxt;
            start            <= start_nxt;
            row_cal_done     <= row_cal_nxt;
            err_timeout      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_weight_seq_ctrl.sv
// tb/tb_weight_seq_ctrl.sv - directed self-checking bench for weight_seq_ctrl
module tb_weight_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_mode = 1'b0;
    logic       in_flag_valid = 1'b0;
    logic [8:0] in_flag = '0;
    logic       in_flag_ready;
    logic       in_wei_valid = 1'b0;
    logic [7:0] in_wei = '0;
    logic       in_wei_ready;
    logic       wr_req_wei_flag;
    logic [8:0] wr_data_wei_flag;
    logic       wr_req_wei;
    logic [7:0] wr_data_wei;
    logic       mode;
    logic       start;
    logic       wei_en = 1'b0;
    logic       row_done = 1'b0;
    logic       row_cal_done;
    logic       busy;
    logic       kernel_done;
    logic       err_timeout;

    weight_seq_ctrl #(
        .KERNEL_SIZE  (9),
        .KERNEL_WIDTH (3),
        .DATA_WIDTH   (8),
        .EN_TIMEOUT   (15)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_mode         (cfg_mode),
        .in_flag_valid    (in_flag_valid),
        .in_flag          (in_flag),
        .in_flag_ready    (in_flag_ready),
        .in_wei_valid     (in_wei_valid),
        .in_wei           (in_wei),
        .in_wei_ready     (in_wei_ready),
        .wr_req_wei_flag  (wr_req_wei_flag),
        .wr_data_wei_flag (wr_data_wei_flag),
        .wr_req_wei       (wr_req_wei),
        .wr_data_wei      (wr_data_wei),
        .mode             (mode),
        .start            (start),
        .wei_en           (wei_en),
        .row_done         (row_done),
        .row_cal_done     (row_cal_done),
        .busy             (busy),
        .kernel_done      (kernel_done),
        .err_timeout      (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [26:0] outs;
    assign outs = {in_flag_ready, in_wei_ready, wr_req_wei_flag, wr_data_wei_flag,
                   wr_req_wei, wr_data_wei, mode, start, row_cal_done, busy,
                   kernel_done, err_timeout};

    // Observation counters, sampled on the falling edge.
    logic [7:0] wei_q[$];
    int         flag_cnt = 0;
    logic [8:0] flag_data = '0;
    int         start_cnt = 0, start_cyc = 0;
    int         rcd_cnt = 0, kd_cnt = 0;
    int         err_cyc = 0;
    logic       err_prev = 1'b0;
    int         flag_hs_cyc = 0, wei_hs_cyc = 0;

    always @(negedge clk) begin
        if (wr_req_wei) wei_q.push_back(wr_data_wei);
        if (wr_req_wei_flag) begin
            flag_cnt++;
            flag_data = wr_data_wei_flag;
        end
        if (in_flag_valid && in_flag_ready) flag_hs_cyc = cyc;
        if (in_wei_valid && in_wei_ready) wei_hs_cyc = cyc;
        if (start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (row_cal_done) rcd_cnt++;
        if (kernel_done) kd_cnt++;
        if (err_timeout && !err_prev) err_cyc = cyc;
        err_prev = err_timeout;
    end

    int compared = 0;
    int mismatched = 0;
    int b_q, b_flag, b_start, b_rcd, b_kd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_q = wei_q.size();
        b_flag = flag_cnt;
        b_start = start_cnt;
        b_rcd = rcd_cnt;
        b_kd = kd_cnt;
    endtask

    task automatic send_flag(input logic [8:0] f, input logic m);
        int n;
        n = 0;
        in_flag = f;
        cfg_mode = m;
        in_flag_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_flag_ready && n < 50);
        check("flag_handshake", 32'(in_flag_ready), 1);
        tick(1);
        in_flag_valid = 1'b0;
    endtask

    task automatic send_weis(input int cnt, input logic [7:0] base, input bit gap);
        int n;
        for (int i = 0; i < cnt; i++) begin
            if (gap) begin
                in_wei_valid = 1'b0;
                in_wei = 8'hEE;
                tick(1);
            end
            in_wei = base + 8'(i);
            in_wei_valid = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!in_wei_ready && n < 50);
            check("wei_handshake", 32'(in_wei_ready), 1);
            tick(1);
        end
        in_wei_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!start && n < 60);
        check("start_seen", 32'(start), 1);
        tick(1);
    endtask

    task automatic check_q(input string tag, input int base, input int cnt, input logic [7:0] first);
        check({tag, "_count"}, 32'(wei_q.size() - base), 32'(cnt));
        for (int i = 0; i < cnt; i++) begin
            if (base + i < wei_q.size())
                check({tag, "_data"}, 32'(wei_q[base + i]), 32'(first + 8'(i)));
        end
    endtask

    initial begin
        int n;

        // Reset state
        tick(2);
        check("reset_outputs", 32'(outs), 0);
        reset = 1'b0;
        tick(1);
        check("idle_flag_ready", 32'(in_flag_ready), 1);
        check("idle_busy", 32'(busy), 0);

        // Sparse kernel, 5 weights, wei_en 3 cycles after start
        snap();
        send_flag(9'b111_000_101, 1'b1);
        check("t1_mode", 32'(mode), 1);
        check("t1_busy", 32'(busy), 1);
        send_weis(5, 8'h11, 1'b0);
        wait_start();
        check("t1_start_latency", 32'(start_cyc - wei_hs_cyc), 2);
        tick(2);
        wei_en = 1'b1;
        tick(1);
        wei_en = 1'b0;
        repeat (3) begin
            row_done = 1'b1;
            tick(1);
            row_done = 1'b0;
            tick(1);
        end
        tick(3);
        check("t1_flag_strobes", 32'(flag_cnt - b_flag), 1);
        check("t1_flag_data", 32'(flag_data), 32'h1C5);
        check_q("t1_wei", b_q, 5, 8'h11);
        check("t1_start_count", 32'(start_cnt - b_start), 1);
        check("t1_row_cal", 32'(rcd_cnt - b_rcd), 3);
        check("t1_kernel_done", 32'(kd_cnt - b_kd), 1);
        check("t1_idle_busy", 32'(busy), 0);

        // Zero-weight flag, back-to-back row_done
        snap();
        send_flag(9'b000_000_000, 1'b1);
        wait_start();
        check("t2_start_latency", 32'(start_cyc - flag_hs_cyc), 2);
        wei_en = 1'b1;
        tick(1);
        wei_en = 1'b0;
        row_done = 1'b1;
        tick(3);
        row_done = 1'b0;
        check("t2_done_pulse", 32'(kernel_done), 1);
        check("t2_done_flag_ready", 32'(in_flag_ready), 0);
        tick(1);
        check("t2_after_done_ready", 32'(in_flag_ready), 1);
        check("t2_after_done_kd", 32'(kernel_done), 0);
        tick(2);
        check("t2_no_weights", 32'(wei_q.size() - b_q), 0);
        check("t2_row_cal", 32'(rcd_cnt - b_rcd), 3);
        check("t2_kernel_done", 32'(kd_cnt - b_kd), 1);

        // Parallel mode, full flag
        snap();
        send_flag(9'h1FF, 1'b0);
        check("t3_mode", 32'(mode), 0);
        send_weis(9, 8'h21, 1'b0);
        wait_start();
        wei_en = 1'b1;
        tick(1);
        wei_en = 1'b0;
        check("t3_done_pulse", 32'(kernel_done), 1);
        tick(3);
        check("t3_flag_data", 32'(flag_data), 32'h1FF);
        check_q("t3_wei", b_q, 9, 8'h21);
        check("t3_row_cal", 32'(rcd_cnt - b_rcd), 0);
        check("t3_kernel_done", 32'(kd_cnt - b_kd), 1);

        // wei_en never arrives
        snap();
        send_flag(9'h000, 1'b1);
        wait_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_timeout && n < 40);
        check("t4_err_seen", 32'(err_timeout), 1);
        check("t4_busy_fall", 32'(busy), 0);
        tick(1);
        check("t4_err_latency", 32'(err_cyc - start_cyc), 15);
        check("t4_no_kernel_done", 32'(kd_cnt - b_kd), 0);
        tick(2);
        check("t4_err_sticky", 32'(err_timeout), 1);
        send_flag(9'h000, 1'b0);
        check("t4_err_cleared", 32'(err_timeout), 0);
        wait_start();
        wei_en = 1'b1;
        tick(1);
        wei_en = 1'b0;
        tick(3);
        check("t4_recover_kd", 32'(kd_cnt - b_kd), 1);

        // Gapped weights with stray row_done / wei_en during load
        snap();
        send_flag(9'h0F0, 1'b1);
        row_done = 1'b1;
        wei_en = 1'b1;
        send_weis(4, 8'h31, 1'b1);
        row_done = 1'b0;
        wei_en = 1'b0;
        wait_start();
        check("t5_start_latency", 32'(start_cyc - wei_hs_cyc), 2);
        check("t5_stray_row", 32'(rcd_cnt - b_rcd), 0);
        check_q("t5_wei", b_q, 4, 8'h31);
        wei_en = 1'b1;
        tick(1);
        wei_en = 1'b0;
        row_done = 1'b1;
        tick(3);
        row_done = 1'b0;
        tick(3);
        check("t5_row_cal", 32'(rcd_cnt - b_rcd), 3);
        check("t5_kernel_done", 32'(kd_cnt - b_kd), 1);

        // Reset mid-kernel in ROW
        snap();
        send_flag(9'h000, 1'b1);
        wait_start();
        wei_en = 1'b1;
        tick(1);
        wei_en = 1'b0;
        row_done = 1'b1;
        tick(1);
        row_done = 1'b0;
        tick(1);
        check("t6_one_row", 32'(rcd_cnt - b_rcd), 1);
        check("t6_busy_pre", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("t6_reset_outputs", 32'(outs), 0);
        tick(2);
        reset = 1'b0;
        row_done = 1'b1;
        tick(1);
        row_done = 1'b0;
        tick(2);
        check("t6_no_row_after_reset", 32'(rcd_cnt - b_rcd), 1);
        check("t6_no_kd_after_reset", 32'(kd_cnt - b_kd), 0);
        check("t6_idle_busy", 32'(busy), 0);
        snap();
        send_flag(9'h003, 1'b1);
        send_weis(2, 8'h41, 1'b0);
        wait_start();
        wei_en = 1'b1;
        tick(1);
        wei_en = 1'b0;
        row_done = 1'b1;
        tick(3);
        row_done = 1'b0;
        tick(3);
        check_q("t6_wei", b_q, 2, 8'h41);
        check("t6_row_cal", 32'(rcd_cnt - b_rcd), 3);
        check("t6_kernel_done", 32'(kd_cnt - b_kd), 1);
        check("t6_start_count", 32'(start_cnt - b_start), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
